// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive line front end.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        LINE_J,
        LINE_K,
        LINE_SE0,
        LINE_SE1
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP1,
        ST_EOP2,
        ST_ERR
    } rx_state_t;

    localparam int unsigned SYNC_ZEROS = 7;
    localparam int unsigned STUFF_RUN  = 6;

    // Classify one D+/D- sample into a line state.
    function automatic line_t classify(input logic dp, input logic dm);
        line_t l;
        unique case ({dp, dm})
            2'b10:   l = LINE_J;
            2'b01:   l = LINE_K;
            2'b00:   l = LINE_SE0;
            default: l = LINE_SE1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/nrzi_line_decoder.sv
// Line classification and NRZI decode against the last J/K level seen.
module nrzi_line_decoder
    import usb_rx_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  bit_en,
    input  logic  dp,
    input  logic  dm,
    input  logic  load_j,
    output line_t line_c,
    output logic  dec_bit_c
);

    logic prev_level;   // 1 = J, 0 = K

    assign line_c    = classify(dp, dm);
    assign dec_bit_c = (dp == prev_level);

    // Tracks every J/K sample, including SYNC and stuffed bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_level <= 1'b1;
        end else if (bit_en) begin
            if (load_j) begin
                prev_level <= 1'b1;
            end else if (line_c == LINE_J || line_c == LINE_K) begin
                prev_level <= dp;
            end
        end
    end

endmodule

// File: rtl/usb_rx_line_frontend.sv
// USB receive front end: SYNC check, NRZI decode, destuffing, EOP detect and
// a qualified serial stream (inb/recving/pause) for the packet decoder.
module usb_rx_line_frontend
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BITS = 88,
    parameter int unsigned IDLE_J   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic dp,
    input  logic dm,
    output logic inb,
    output logic recving,
    output logic pause,
    output logic eop,
    output logic rx_err
);

    localparam int unsigned ZERO_CW = 4;
    localparam int unsigned ONES_CW = 3;
    localparam int unsigned BIT_CW  = $clog2(MAX_BITS + 1);
    localparam int unsigned J_CW    = $clog2(IDLE_J + 1);

    rx_state_t            state, state_nx;
    logic [ZERO_CW-1:0]   zero_cnt, zero_nx;
    logic [ONES_CW-1:0]   ones_cnt, ones_nx;
    logic [BIT_CW-1:0]    bit_cnt, bit_nx;
    logic [J_CW-1:0]      j_cnt, j_nx;
    logic                 inb_nx, recving_nx, pause_nx, eop_nx, err_nx;
    logic                 load_j_c;
    line_t                line_c;
    logic                 dec_bit_c;
    logic                 is_jk_c;

    nrzi_line_decoder u_nrzi (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .dp        (dp),
        .dm        (dm),
        .load_j    (load_j_c),
        .line_c    (line_c),
        .dec_bit_c (dec_bit_c)
    );

    assign is_jk_c = (line_c == LINE_J) || (line_c == LINE_K);

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            zero_cnt <= '0;
            ones_cnt <= '0;
            bit_cnt  <= '0;
            j_cnt    <= '0;
            inb      <= 1'b0;
            recving  <= 1'b0;
            pause    <= 1'b1;
            eop      <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_nx;
            zero_cnt <= zero_nx;
            ones_cnt <= ones_nx;
            bit_cnt  <= bit_nx;
            j_cnt    <= j_nx;
            inb      <= inb_nx;
            recving  <= recving_nx;
            pause    <= pause_nx;
            eop      <= eop_nx;
            rx_err   <= err_nx;
        end
    end

    // Next state and next outputs; nothing moves without bit_en.
    always_comb begin
        logic to_err;
        state_nx   = state;
        zero_nx    = zero_cnt;
        ones_nx    = ones_cnt;
        bit_nx     = bit_cnt;
        j_nx       = j_cnt;
        inb_nx     = inb;
        recving_nx = recving;
        pause_nx   = 1'b1;
        eop_nx     = 1'b0;
        err_nx     = 1'b0;
        load_j_c   = 1'b0;
        to_err     = 1'b0;

        if (bit_en) begin
            unique case (state)
                ST_IDLE: begin
                    if (line_c == LINE_K) begin
                        state_nx = ST_SYNC;
                        zero_nx  = ZERO_CW'(1);
                    end
                end
                ST_SYNC: begin
                    if (!is_jk_c) begin
                        to_err = 1'b1;
                    end else if (!dec_bit_c) begin
                        if (zero_cnt == ZERO_CW'(SYNC_ZEROS)) to_err = 1'b1;
                        else zero_nx = zero_cnt + ZERO_CW'(1);
                    end else if (zero_cnt == ZERO_CW'(SYNC_ZEROS)) begin
                        // SYNC's closing 1 starts the ones run but is not forwarded.
                        state_nx = ST_DATA;
                        ones_nx  = ONES_CW'(1);
                        bit_nx   = '0;
                    end else begin
                        to_err = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (line_c == LINE_SE0) begin
                        state_nx   = ST_EOP1;
                        recving_nx = 1'b0;
                    end else if (line_c == LINE_SE1) begin
                        to_err = 1'b1;
                    end else if (ones_cnt == ONES_CW'(STUFF_RUN)) begin
                        if (dec_bit_c) to_err = 1'b1;
                        else ones_nx = '0;
                    end else if (bit_cnt == BIT_CW'(MAX_BITS)) begin
                        to_err = 1'b1;
                    end else begin
                        inb_nx     = dec_bit_c;
                        pause_nx   = 1'b0;
                        recving_nx = 1'b1;
                        bit_nx     = bit_cnt + BIT_CW'(1);
                        ones_nx    = dec_bit_c ? ones_cnt + ONES_CW'(1) : '0;
                    end
                end
                ST_EOP1: begin
                    if (line_c == LINE_SE0) state_nx = ST_EOP2;
                    else to_err = 1'b1;
                end
                ST_EOP2: begin
                    if (line_c == LINE_J) begin
                        state_nx = ST_IDLE;
                        eop_nx   = 1'b1;
                        load_j_c = 1'b1;
                    end else begin
                        to_err = 1'b1;
                    end
                end
                ST_ERR: begin
                    if (line_c == LINE_J) begin
                        if (j_cnt == J_CW'(IDLE_J - 1)) begin
                            state_nx = ST_IDLE;
                            j_nx     = '0;
                            load_j_c = 1'b1;
                        end else begin
                            j_nx = j_cnt + J_CW'(1);
                        end
                    end else begin
                        j_nx = '0;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase

            if (to_err) begin
                state_nx   = ST_ERR;
                err_nx     = 1'b1;
                recving_nx = 1'b0;
                j_nx       = '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_line_frontend.sv
// Directed bench for usb_rx_line_frontend: ACK, stuffing, line errors,
// over-length and mid-packet reset.
module tb_usb_rx_line_frontend;

    logic clk = 1'b0;
    logic rst, bit_en, dp, dm;
    logic inb, recving, pause, eop, rx_err;

    usb_rx_line_frontend #(.MAX_BITS(88), .IDLE_J(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .dp      (dp),
        .dm      (dm),
        .inb     (inb),
        .recving (recving),
        .pause   (pause),
        .eop     (eop),
        .rx_err  (rx_err)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   gap     = 1;
    logic cur_lvl = 1'b1;
    int   cyc     = 0;

    logic rx_bits[$];
    int   bit_cyc[$];
    int   eop_cnt = 0, err_cnt = 0, recv_bad = 0, recv_seen = 0, err_recv = 0;
    int   last_eop_cyc = 0;
    int   b_bits, b_eop, b_err, b_bad, b_seen, b_erec;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe registered outputs mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!pause) begin
                rx_bits.push_back(inb);
                bit_cyc.push_back(cyc);
                if (!recving) recv_bad++;
            end
            if (recving) recv_seen++;
            if (eop) begin
                eop_cnt++;
                last_eop_cyc = cyc;
            end
            if (rx_err) begin
                err_cnt++;
                if (recving) err_recv++;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic mark();
        b_bits = rx_bits.size();
        b_eop  = eop_cnt;
        b_err  = err_cnt;
        b_bad  = recv_bad;
        b_seen = recv_seen;
        b_erec = err_recv;
    endtask

    function automatic int nbits();
        return rx_bits.size() - b_bits;
    endfunction

    function automatic int got_word(input int n);
        int w = 0;
        for (int i = 0; i < n && i < 32; i++)
            if (b_bits + i < rx_bits.size() && rx_bits[b_bits + i] === 1'b1) w |= (1 << i);
        return w;
    endfunction

    function automatic int cyc_of(input int i);
        return (b_bits + i < bit_cyc.size()) ? bit_cyc[b_bits + i] : -1000;
    endfunction

    task automatic send_line(input logic p, input logic m);
        dp = p;
        dm = m;
        bit_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < gap; i++) begin
            bit_en = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_lvl(input logic l);
        cur_lvl = l;
        send_line(l, ~l);
    endtask

    task automatic send_bit(input logic b);
        send_lvl(b ? cur_lvl : ~cur_lvl);
    endtask

    task automatic send_bits(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic send_sync();
        send_lvl(0); send_lvl(1); send_lvl(0); send_lvl(1);
        send_lvl(0); send_lvl(1); send_lvl(0); send_lvl(0);
    endtask

    task automatic send_eop();
        send_line(0, 0);
        send_line(0, 0);
        send_lvl(1);
    endtask

    task automatic quiet(input int n);
        bit_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic recover();
        repeat (8) send_lvl(1);
        quiet(3);
    endtask

    task automatic send_ack();
        send_sync();
        send_bits(128'hD2, 8);
        send_eop();
        quiet(4);
    endtask

    localparam logic [127:0] ALT = {4{32'hAAAA_AAAA}};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bit_en = 1'b0; dp = 1'b1; dm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inb", int'(inb), 0);
        check("rst_recving", int'(recving), 0);
        check("rst_pause", int'(pause), 1);
        check("rst_eop", int'(eop), 0);
        check("rst_err", int'(rx_err), 0);
        rst = 1'b0;
        quiet(3);
        check("idle_pause", int'(pause), 1);

        // ACK, back-to-back bit_en
        mark();
        send_ack();
        check("ack_nbits", nbits(), 8);
        check("ack_pid", got_word(8), 'hD2);
        check("ack_eop", eop_cnt - b_eop, 1);
        check("ack_err", err_cnt - b_err, 0);
        check("ack_recv_qual", recv_bad - b_bad, 0);
        check("ack_recv_cycles", recv_seen - b_seen, 8);
        check("ack_eop_lat", last_eop_cyc - cyc_of(7), 3);
        check("ack_inb_hold", int'(inb), 1);
        check("ack_recv_low", int'(recving), 0);

        // 0xFF,0x00: the SYNC's final 1 plus five payload 1s forces a stuffed 0
        mark();
        send_sync();
        send_bits(128'h1DF, 17);
        send_eop();
        quiet(4);
        check("stuff_nbits", nbits(), 16);
        check("stuff_data", got_word(16), 'h00FF);
        check("stuff_slot", cyc_of(5) - cyc_of(4), 2);
        check("stuff_span", cyc_of(15) - cyc_of(0), 16);
        check("stuff_bit_after", got_word(16) >> 5 & 1, 1);
        check("stuff_eop", eop_cnt - b_eop, 1);
        check("stuff_err", err_cnt - b_err, 0);

        // seven decoded 1s in a row
        mark();
        send_sync();
        send_bits(128'h3F, 6);
        quiet(3);
        check("serr_nbits", nbits(), 5);
        check("serr_err", err_cnt - b_err, 1);
        check("serr_recv_at_err", err_recv - b_erec, 0);
        check("serr_recv_low", int'(recving), 0);
        check("serr_eop", eop_cnt - b_eop, 0);

        // 5 J, K, 7 J must not re-arm
        repeat (5) send_lvl(1);
        send_lvl(0);
        repeat (7) send_lvl(1);
        mark();
        send_ack();
        check("err_hold_nbits", nbits(), 0);
        check("err_hold_eop", eop_cnt - b_eop, 0);
        check("err_hold_err", err_cnt - b_err, 0);
        recover();
        mark();
        send_ack();
        check("err_exit_pid", got_word(8), 'hD2);
        check("err_exit_eop", eop_cnt - b_eop, 1);

        // SYNC cut by SE0
        mark();
        send_lvl(0); send_lvl(1); send_lvl(0); send_lvl(1); send_lvl(0); send_lvl(1);
        send_line(0, 0);
        quiet(3);
        check("sync_se0_err", err_cnt - b_err, 1);
        check("sync_se0_recv", recv_seen - b_seen, 0);
        recover();

        // eight zeros with no closing 1
        mark();
        for (int i = 0; i < 8; i++) send_lvl(i[0]);
        quiet(3);
        check("sync_8z_err", err_cnt - b_err, 1);
        check("sync_8z_recv", recv_seen - b_seen, 0);
        recover();

        // 89 payload bits
        mark();
        send_sync();
        send_bits(ALT, 89);
        quiet(3);
        check("long_nbits", nbits(), 88);
        check("long_data", got_word(32), int'(32'hAAAA_AAAA));
        check("long_err", err_cnt - b_err, 1);
        check("long_eop", eop_cnt - b_eop, 0);
        recover();

        // exactly 88 payload bits
        mark();
        send_sync();
        send_bits(ALT, 88);
        send_eop();
        quiet(4);
        check("max_nbits", nbits(), 88);
        check("max_eop", eop_cnt - b_eop, 1);
        check("max_err", err_cnt - b_err, 0);

        // reset mid-DATA with sparse bit_en
        gap = 4;
        mark();
        send_sync();
        send_bits(ALT, 20);
        check("mid_nbits", nbits(), 20);
        check("mid_recving", int'(recving), 1);
        rst = 1'b1;
        #2;
        check("mid_rst_inb", int'(inb), 0);
        check("mid_rst_recving", int'(recving), 0);
        check("mid_rst_pause", int'(pause), 1);
        check("mid_rst_eop", int'(eop), 0);
        check("mid_rst_err", int'(rx_err), 0);
        @(posedge clk); #1;
        dp = 1'b1; dm = 1'b0; bit_en = 1'b0; cur_lvl = 1'b1;
        rst = 1'b0;
        quiet(2);
        mark();
        send_ack();
        check("post_rst_nbits", nbits(), 8);
        check("post_rst_pid", got_word(8), 'hD2);
        check("post_rst_eop", eop_cnt - b_eop, 1);
        check("post_rst_err", err_cnt - b_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
